lsu_mem_access: RTL
===================

LSU_MEM_ACCESS -- requirements
Module: lsu_mem_access

Interface
REQ-001 Parameter: ADDR_W, default 10, word-address width driven to data memory.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  access request present.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 rsp_err  output  1  access faulted, valid with rsp_valid.
REQ-013 mem_addr  output  ADDR_W  word address to data memory.
REQ-014 mem_we  output  1  data memory write enable.
REQ-015 mem_din  output  32  full word written to data memory.
REQ-016 mem_dout  input  32  combinational read data from data memory at mem_addr.

Function
REQ-017 FSM states IDLE, ACCESS, RESP; IDLE->ACCESS on req_valid; ACCESS->RESP always; RESP->IDLE always.
REQ-018 req_ready SHALL be 1 only in IDLE; request fields are registered on acceptance.
REQ-019 Latency fixed: accept at cycle 0, memory access at cycle 1, rsp_valid high for exactly cycle 2; no backpressure on response.
REQ-020 mem_addr = registered addr[ADDR_W+1:2]; upper address bits ignored (wrap-around modulo 2^(ADDR_W+2) bytes).
REQ-021 mem_we SHALL assert only in ACCESS, for a non-faulting store, for exactly one cycle.
REQ-022 SW writes req_wdata; SB/SH read mem_dout, replace only the addressed byte/halfword lane (addr[1:0]), write merged word in the same ACCESS cycle.
REQ-023 Loads capture the addressed lane from mem_dout in ACCESS; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-024 Undefined funct3 (loads 011/110/111, stores 011-111) SHALL set rsp_err=1, suppress mem_we, rsp_rdata=0.
REQ-025 mem_din SHALL be 0 whenever mem_we is 0.

Reset
REQ-026 On rst: state=IDLE, req_ready=1 after reset release, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-027 rst asserted in ACCESS SHALL suppress mem_we that cycle; rst in any state discards the in-flight request with no response.

Configuration
REQ-028 Macro LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, SHALL complete with rsp_err=1, no memory write, rsp_rdata=0.
REQ-029 Macro undefined: misaligned accesses SHALL force the offending low address bits to 0 (natural alignment) and complete normally with rsp_err=0.

Structure
REQ-030 Shared package lsu_pkg: funct3 constants for each load/store, FSM state typedef, lane-offset type.
REQ-031 One combinational sub-module lsu_align: lane extract with sign/zero extension and lane merge for stores; FSM and registers stay in lsu_mem_access.

Verification
REQ-032 Memory word 5 = 0x8077_F0A1; LB addr 0x14 -> rsp_rdata 0xFFFF_FFA1 at cycle 2; LBU addr 0x15 -> 0x0000_00F0.
REQ-033 Word 3 = 0x1122_3344; SB addr 0x0E data 0xAB -> word 3 = 0x11AB_3344, mem_we high exactly one cycle.
REQ-034 LH addr 0x03: with LSU_MISALIGN_TRAP_EN -> rsp_err=1, rdata 0; without -> reads halfword at 0x02, rsp_err=0.
REQ-035 funct3=011 store to addr 0x20 -> rsp_err=1, mem_we never asserts, word 8 unchanged.
REQ-036 rst pulsed during ACCESS of SW 0xDEAD_BEEF to 0x40 -> word 16 unchanged, no rsp_valid, req_ready=1 in the cycle after reset release.
REQ-037 Back-to-back req_valid held high: accepts once every 3 cycles, req_ready low in ACCESS and RESP; address 0x1004 with ADDR_W=10 accesses word 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state and lane-offset types for the LSU
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } lsu_state_t;

    typedef logic [1:0] lane_off_t;

    // Stores only define SB/SH/SW; loads additionally define the unsigned variants.
    function automatic logic f3_valid(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load lane extract/extend and store lane merge
import lsu_pkg::*;

module lsu_align (
    input  logic [2:0]  funct3_i,
    input  lane_off_t   off_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);

    logic [7:0]  byte_l;
    logic [15:0] half_l;

    always_comb begin
        byte_l = rdata_i[{off_i, 3'b000} +: 8];
        half_l = rdata_i[{off_i[1], 4'b0000} +: 16];
        case (funct3_i)
            F3_LB:   load_o = {{24{byte_l[7]}}, byte_l};
            F3_LH:   load_o = {{16{half_l[15]}}, half_l};
            F3_LW:   load_o = rdata_i;
            F3_LBU:  load_o = {24'h0, byte_l};
            F3_LHU:  load_o = {16'h0, half_l};
            default: load_o = 32'h0;
        endcase
    end

    // Sub-word stores read-modify-write the word currently on rdata_i.
    always_comb begin
        store_o = rdata_i;
        case (funct3_i)
            F3_SB:   store_o[{off_i, 3'b000} +: 8]     = wdata_i[7:0];
            F3_SH:   store_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            default: store_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - 3-cycle load/store unit; LSU_MISALIGN_TRAP_EN traps misaligned accesses
import lsu_pkg::*;

module lsu_mem_access #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    lsu_state_t        state_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              rsp_valid_q;

    logic              fault;
    lane_off_t         off_eff;
    logic [31:0]       load_data;
    logic [31:0]       store_data;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    always_comb begin
        off_eff = addr_q[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        fault = !f3_valid(we_q, funct3_q) ||
                ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
        fault = !f3_valid(we_q, funct3_q);
        if (funct3_q[1:0] == 2'b01) begin
            off_eff[0] = 1'b0;
        end else if (funct3_q[1:0] == 2'b10) begin
            off_eff = 2'b00;
        end
`endif
        err_d   = fault;
        rdata_d = (we_q || fault) ? 32'h0 : load_data;
    end

    lsu_align u_align (
        .funct3_i (funct3_q),
        .off_i    (off_eff),
        .rdata_i  (mem_dout),
        .wdata_i  (wdata_q),
        .load_o   (load_data),
        .store_o  (store_data)
    );

    // rst gates the write combinationally so a reset landing in ACCESS never commits.
    assign mem_we    = (state_q == S_ACCESS) && we_q && !fault && !rst;
    assign mem_din   = mem_we ? store_data : 32'h0;
    assign mem_addr  = addr_q[ADDR_W+1:2];
    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= 32'h0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        funct3_q <= req_funct3;
                        addr_q   <= req_addr[ADDR_W+1:0];
                        wdata_q  <= req_wdata;
                        state_q  <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    rdata_q     <= rdata_d;
                    err_q       <= err_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    rdata_q     <= 32'h0;
                    err_q       <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
